// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requesting control unit and serial_sub_ctrl.
interface serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A-B: steps one shared full subtractor over WIDTH cycles, LSB first,
// then publishes the result word and final borrow with a one-cycle done pulse.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_sub_ctrl_if.slave   bus
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RES_W = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             fs_diff;
  logic             fs_bout;
  logic             last_bit;

  Lab2_full_sub u_fs (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .bin  (borrow_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SHIFT;
          opa_d    = bus.a;
          opb_d    = bus.b;
          res_d    = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      SHIFT: begin
        // The final bit goes straight to diff, so res only needs WIDTH-1 bits
        res_d    = RES_W'({fs_diff, res_q} >> 1);
        opa_d    = opa_q >> 1;
        opb_d    = opb_q >> 1;
        borrow_d = fs_bout;
        if (last_bit) begin
          state_d = DONE;
          diff_d  = {fs_diff, res_q};
          bout_d  = fs_bout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// One-bit full subtractor: diff = a - b - bin, bout set when a borrow is needed.
module Lab2_full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 scenarios plus a WIDTH=4 exhaustive sweep.
module tb_serial_sub_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_sub_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 operation from idle; returns one cycle after done.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb);
    int cyc;
    int busy_cnt;
    bus8.a = av;
    bus8.b = bv;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    bus8.a = ~av;
    bus8.b = ~bv;
    cyc = 0;
    busy_cnt = 0;
    while (!bus8.done && cyc < 40) begin
      if (bus8.busy) busy_cnt++;
      tick();
      cyc++;
    end
    check_eq({tag, " latency"}, 32'(cyc), 32'd8);
    check_eq({tag, " busy_cycles"}, 32'(busy_cnt), 32'd8);
    check_eq({tag, " diff"}, 32'(bus8.diff), 32'(ed));
    check_eq({tag, " bout"}, 32'(bus8.bout), 32'(eb));
    tick();
    check_eq({tag, " done_pulse"}, 32'(bus8.done), 32'd0);
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv);
    int cyc;
    logic [3:0] ed;
    logic       eb;
    ed = 4'(av - bv);
    eb = (av < bv);
    bus4.a = av;
    bus4.b = bv;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    cyc = 0;
    while (!bus4.done && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq($sformatf("w4 %0h-%0h latency", av, bv), 32'(cyc), 32'd4);
    check_eq($sformatf("w4 %0h-%0h diff", av, bv), 32'(bus4.diff), 32'(ed));
    check_eq($sformatf("w4 %0h-%0h bout", av, bv), 32'(bus4.bout), 32'(eb));
    tick();
  endtask

  initial begin
    int dones;
    int cyc;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    tick();
    tick();
    check_eq("reset busy", 32'(bus8.busy), 32'd0);
    check_eq("reset done", 32'(bus8.done), 32'd0);
    check_eq("reset diff", 32'(bus8.diff), 32'd0);
    check_eq("reset bout", 32'(bus8.bout), 32'd0);
    rst = 1'b0;
    tick();

    run8("5A-3C", 8'h5A, 8'h3C, 8'h1E, 1'b0);
    run8("00-01", 8'h00, 8'h01, 8'hFF, 1'b1);
    run8("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
    run8("80-7F", 8'h80, 8'h7F, 8'h01, 1'b0);

    // start held high: back-to-back operations every WIDTH+2 cycles
    bus8.a = 8'h10;
    bus8.b = 8'h20;
    bus8.start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      cyc = 0;
      while (!bus8.done && cyc < 40) begin
        tick();
        cyc++;
      end
      check_eq($sformatf("hold%0d latency", i), 32'(cyc), 32'd8);
      check_eq($sformatf("hold%0d diff", i), 32'(bus8.diff), 32'hF0);
      check_eq($sformatf("hold%0d bout", i), 32'(bus8.bout), 32'd1);
      bus8.a = 8'h10;
      bus8.b = 8'h20;
      if (i == 2) bus8.start = 1'b0;
      tick();
      check_eq($sformatf("hold%0d done_drop", i), 32'(bus8.done), 32'd0);
      check_eq($sformatf("hold%0d idle_busy", i), 32'(bus8.busy), 32'd0);
      tick();
      check_eq($sformatf("hold%0d restart", i), 32'(bus8.busy), (i == 2) ? 32'd0 : 32'd1);
    end

    // asynchronous reset in the middle of SHIFT discards the operation
    bus8.a = 8'h33;
    bus8.b = 8'h11;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst busy", 32'(bus8.busy), 32'd0);
    check_eq("midrst diff", 32'(bus8.diff), 32'd0);
    check_eq("midrst bout", 32'(bus8.bout), 32'd0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) dones++;
      tick();
    end
    check_eq("midrst no_done", 32'(dones), 32'd0);
    run8("33-11", 8'h33, 8'h11, 8'h22, 1'b0);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        run4(4'(ai), 4'(bi));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
